// File: rtl/dual_issue_dispatch.sv
// Dual-issue, in-order dispatch from a two-entry queue head into Tomasulo reservation stations.
// Renames destinations through a register status table and frees entries on CDB broadcasts.
module dual_issue_dispatch #(
  parameter int unsigned NUM_ADD_RS = 3,
  parameter int unsigned NUM_MUL_RS = 2,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned TAG_W      = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [7:0]                       inst1_type,
  input  logic [7:0]                       inst1_destination_reg,
  input  logic [7:0]                       inst1_source_reg1,
  input  logic [7:0]                       inst1_source_reg2,
  input  logic [7:0]                       inst2_type,
  input  logic [7:0]                       inst2_destination_reg,
  input  logic [7:0]                       inst2_source_reg1,
  input  logic [7:0]                       inst2_source_reg2,
  output logic [1:0]                       select_instruction,
  input  logic                             cdb_valid,
  input  logic [TAG_W-1:0]                 cdb_tag,
  output logic                             issue0_valid,
  output logic                             issue1_valid,
  output logic [TAG_W-1:0]                 issue0_rs,
  output logic [TAG_W-1:0]                 issue1_rs,
  output logic [7:0]                       issue0_op,
  output logic [7:0]                       issue1_op,
  output logic [7:0]                       issue0_dest,
  output logic [7:0]                       issue1_dest,
  output logic [7:0]                       issue0_src1,
  output logic [7:0]                       issue0_src2,
  output logic [7:0]                       issue1_src1,
  output logic [7:0]                       issue1_src2,
  output logic [TAG_W-1:0]                 issue0_qj,
  output logic [TAG_W-1:0]                 issue0_qk,
  output logic [TAG_W-1:0]                 issue1_qj,
  output logic [TAG_W-1:0]                 issue1_qk,
  output logic [NUM_ADD_RS+NUM_MUL_RS-1:0] rs_busy
);

  localparam int unsigned NUM_RS = NUM_ADD_RS + NUM_MUL_RS;
  localparam int unsigned REG_W  = $clog2(NUM_REGS);
  localparam logic [NUM_RS-1:0] MUL_MASK = {{NUM_MUL_RS{1'b1}}, {NUM_ADD_RS{1'b0}}};

  function automatic logic [TAG_W-1:0] f_pick(input logic [NUM_RS-1:0] free);
    logic [TAG_W-1:0] t;
    t = '0;
    for (int i = int'(NUM_RS) - 1; i >= 0; i--) begin
      if (free[i]) t = TAG_W'(i + 1);
    end
    return t;
  endfunction

  // Out-of-range tags (including 0) decode to an empty mask.
  function automatic logic [NUM_RS-1:0] f_onehot(input logic [TAG_W-1:0] t);
    logic [NUM_RS-1:0] m;
    for (int i = 0; i < int'(NUM_RS); i++) m[i] = (t == TAG_W'(i + 1));
    return m;
  endfunction

  function automatic logic [TAG_W-1:0] f_bypass(input logic [TAG_W-1:0] st, input logic cv,
                                                input logic [TAG_W-1:0] ct);
    return (cv && st == ct) ? '0 : st;
  endfunction

  logic [TAG_W-1:0]  r_status [NUM_REGS];
  logic [TAG_W-1:0]  w_status_d [NUM_REGS];
  logic [NUM_RS-1:0] r_busy, w_busy_d;

  logic              w_i1_valid, w_i2_valid, w_i1_mul, w_i2_mul;
  logic              w_iss1, w_iss2;
  logic [TAG_W-1:0]  w_tag1, w_tag2;
  logic [NUM_RS-1:0] w_alloc1, w_alloc2;
  logic [REG_W-1:0]  w_d1, w_d2, w_a1, w_b1, w_a2, w_b2;
  logic [TAG_W-1:0]  w_qj1, w_qk1, w_qj2, w_qk2;

  logic              r_v0, r_v1;
  logic [TAG_W-1:0]  r_rs0, r_rs1, r_qj0, r_qk0, r_qj1, r_qk1;
  logic [7:0]        r_op0, r_op1, r_dst0, r_dst1, r_s10, r_s20, r_s11, r_s21;

  assign w_d1 = inst1_destination_reg[REG_W-1:0];
  assign w_a1 = inst1_source_reg1[REG_W-1:0];
  assign w_b1 = inst1_source_reg2[REG_W-1:0];
  assign w_d2 = inst2_destination_reg[REG_W-1:0];
  assign w_a2 = inst2_source_reg1[REG_W-1:0];
  assign w_b2 = inst2_source_reg2[REG_W-1:0];

  always_comb begin
    w_i1_valid = (inst1_type != 8'h00);
    w_i2_valid = (inst2_type != 8'h00);
    w_i1_mul   = (inst1_type == 8'h03) || (inst1_type == 8'h04);
    w_i2_mul   = (inst2_type == 8'h03) || (inst2_type == 8'h04);
    w_tag1     = f_pick(~r_busy & (w_i1_mul ? MUL_MASK : ~MUL_MASK));
    w_iss1     = w_i1_valid && (w_tag1 != '0);
    w_alloc1   = w_iss1 ? f_onehot(w_tag1) : '0;
    w_tag2     = f_pick(~r_busy & ~w_alloc1 & (w_i2_mul ? MUL_MASK : ~MUL_MASK));
    w_iss2     = w_iss1 && w_i2_valid && (w_tag2 != '0);
    w_alloc2   = w_iss2 ? f_onehot(w_tag2) : '0;
  end

  always_comb begin
    if (!rst_n)      select_instruction = 2'b00;
    else if (w_iss2) select_instruction = 2'b10;
    else if (w_iss1) select_instruction = 2'b01;
    else             select_instruction = 2'b00;
  end

  // inst2 sources that match inst1's destination take inst1's new tag over anything else.
  always_comb begin
    w_qj1 = f_bypass(r_status[w_a1], cdb_valid, cdb_tag);
    w_qk1 = f_bypass(r_status[w_b1], cdb_valid, cdb_tag);
    w_qj2 = f_bypass(r_status[w_a2], cdb_valid, cdb_tag);
    w_qk2 = f_bypass(r_status[w_b2], cdb_valid, cdb_tag);
    if (w_iss1 && w_a2 == w_d1) w_qj2 = w_tag1;
    if (w_iss1 && w_b2 == w_d1) w_qk2 = w_tag1;
  end

  always_comb begin
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      w_status_d[r] = r_status[r];
      if (cdb_valid && cdb_tag != '0 && r_status[r] == cdb_tag) w_status_d[r] = '0;
    end
    if (w_iss1) w_status_d[w_d1] = w_tag1;
    if (w_iss2) w_status_d[w_d2] = w_tag2;
  end

  always_comb begin
    w_busy_d = r_busy;
    if (cdb_valid) w_busy_d = w_busy_d & ~f_onehot(cdb_tag);
    w_busy_d = w_busy_d | w_alloc1 | w_alloc2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      for (int r = 0; r < int'(NUM_REGS); r++) r_status[r] <= '0;
      r_v0   <= 1'b0;  r_v1   <= 1'b0;
      r_rs0  <= '0;    r_rs1  <= '0;
      r_qj0  <= '0;    r_qk0  <= '0;
      r_qj1  <= '0;    r_qk1  <= '0;
      r_op0  <= '0;    r_op1  <= '0;
      r_dst0 <= '0;    r_dst1 <= '0;
      r_s10  <= '0;    r_s20  <= '0;
      r_s11  <= '0;    r_s21  <= '0;
    end else begin
      r_busy <= w_busy_d;
      for (int r = 0; r < int'(NUM_REGS); r++) r_status[r] <= w_status_d[r];
      r_v0 <= w_iss1;
      r_v1 <= w_iss2;
      if (w_iss1) begin
        r_rs0  <= w_tag1;            r_op0 <= inst1_type;
        r_dst0 <= inst1_destination_reg;
        r_s10  <= inst1_source_reg1; r_s20 <= inst1_source_reg2;
        r_qj0  <= w_qj1;             r_qk0 <= w_qk1;
      end
      if (w_iss2) begin
        r_rs1  <= w_tag2;            r_op1 <= inst2_type;
        r_dst1 <= inst2_destination_reg;
        r_s11  <= inst2_source_reg1; r_s21 <= inst2_source_reg2;
        r_qj1  <= w_qj2;             r_qk1 <= w_qk2;
      end
    end
  end

  assign rs_busy      = r_busy;
  assign issue0_valid = r_v0;
  assign issue1_valid = r_v1;
  assign issue0_rs    = r_rs0;
  assign issue1_rs    = r_rs1;
  assign issue0_op    = r_op0;
  assign issue1_op    = r_op1;
  assign issue0_dest  = r_dst0;
  assign issue1_dest  = r_dst1;
  assign issue0_src1  = r_s10;
  assign issue0_src2  = r_s20;
  assign issue1_src1  = r_s11;
  assign issue1_src2  = r_s21;
  assign issue0_qj    = r_qj0;
  assign issue0_qk    = r_qk0;
  assign issue1_qj    = r_qj1;
  assign issue1_qk    = r_qk1;

endmodule

// File: tb/tb_dual_issue_dispatch.sv
// Directed, table-driven bench for dual_issue_dispatch with hand-computed expectations.
module tb_dual_issue_dispatch;

  logic       clk, rst_n;
  logic [7:0] t1, d1, a1, b1, t2, d2, a2, b2;
  logic [1:0] sel;
  logic       cv;
  logic [2:0] ct;
  logic       v0, v1;
  logic [2:0] rs0, rs1, qj0, qk0, qj1, qk1;
  logic [7:0] op0, op1, dst0, dst1, s10, s20, s11, s21;
  logic [4:0] busy;

  int tests = 0;
  int fails = 0;

  dual_issue_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .inst1_type(t1), .inst1_destination_reg(d1), .inst1_source_reg1(a1),
    .inst1_source_reg2(b1),
    .inst2_type(t2), .inst2_destination_reg(d2), .inst2_source_reg1(a2),
    .inst2_source_reg2(b2),
    .select_instruction(sel), .cdb_valid(cv), .cdb_tag(ct),
    .issue0_valid(v0), .issue1_valid(v1), .issue0_rs(rs0), .issue1_rs(rs1),
    .issue0_op(op0), .issue1_op(op1), .issue0_dest(dst0), .issue1_dest(dst1),
    .issue0_src1(s10), .issue0_src2(s20), .issue1_src1(s11), .issue1_src2(s21),
    .issue0_qj(qj0), .issue0_qk(qk0), .issue1_qj(qj1), .issue1_qk(qk1),
    .rs_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] t1, d1, a1, b1, t2, d2, a2, b2;
    logic       cv;
    logic [2:0] ct;
    logic [1:0] sel;
    logic       v0;
    logic [2:0] rs0, qj0, qk0;
    logic       v1;
    logic [2:0] rs1, qj1, qk1;
    logic [4:0] busy;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_inst(input logic [7:0] it1, id1, ia1, ib1, it2, id2, ia2, ib2);
    t1 = it1; d1 = id1; a1 = ia1; b1 = ib1;
    t2 = it2; d2 = id2; a2 = ia2; b2 = ib2;
  endtask

  initial begin
    // Sequential vectors: each row depends on the RS/status state left by the rows above it.
    vecs[0]  = '{8'h01, 8'd1, 8'd2, 8'd3, 8'h02, 8'd1, 8'd1, 8'd2, 1'b0, 3'd0,
                 2'b10, 1'b1, 3'd1, 3'd0, 3'd0, 1'b1, 3'd2, 3'd1, 3'd0, 5'b00011};
    vecs[1]  = '{8'h00, 8'd0, 8'd0, 8'd0, 8'h01, 8'd4, 8'd5, 8'd6, 1'b1, 3'd1,
                 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 5'b00010};
    vecs[2]  = '{8'h00, 8'd0, 8'd0, 8'd0, 8'h00, 8'd0, 8'd0, 8'd0, 1'b1, 3'd2,
                 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 5'b00000};
    vecs[3]  = '{8'h01, 8'd1, 8'd2, 8'd3, 8'h03, 8'd4, 8'd5, 8'd6, 1'b0, 3'd0,
                 2'b10, 1'b1, 3'd1, 3'd0, 3'd0, 1'b1, 3'd4, 3'd0, 3'd0, 5'b01001};
    vecs[4]  = '{8'h01, 8'd3, 8'd1, 8'd1, 8'h00, 8'd0, 8'd0, 8'd0, 1'b1, 3'd1,
                 2'b01, 1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 5'b01010};
    vecs[5]  = '{8'h01, 8'd5, 8'd1, 8'd3, 8'h04, 8'd6, 8'd4, 8'd1, 1'b0, 3'd0,
                 2'b10, 1'b1, 3'd1, 3'd0, 3'd2, 1'b1, 3'd5, 3'd4, 3'd0, 5'b11011};
    vecs[6]  = '{8'h01, 8'd7, 8'd0, 8'd0, 8'h01, 8'd7, 8'd7, 8'd5, 1'b1, 3'd1,
                 2'b01, 1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 5'b11110};
    vecs[7]  = '{8'h02, 8'd8, 8'd5, 8'd7, 8'h03, 8'd9, 8'd8, 8'd8, 1'b1, 3'd2,
                 2'b01, 1'b1, 3'd1, 3'd0, 3'd3, 1'b0, 3'd0, 3'd0, 3'd0, 5'b11101};
    vecs[8]  = '{8'h00, 8'd0, 8'd0, 8'd0, 8'h00, 8'd0, 8'd0, 8'd0, 1'b1, 3'd3,
                 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 5'b11001};
    vecs[9]  = '{8'h01, 8'd8, 8'd3, 8'd8, 8'h05, 8'd8, 8'd8, 8'd3, 1'b1, 3'd7,
                 2'b10, 1'b1, 3'd2, 3'd0, 3'd1, 1'b1, 3'd3, 3'd2, 3'd0, 5'b11111};
    vecs[10] = '{8'h03, 8'd10, 8'd8, 8'd7, 8'h00, 8'd0, 8'd0, 8'd0, 1'b1, 3'd2,
                 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 5'b11101};
    vecs[11] = '{8'h01, 8'd11, 8'h18, 8'd0, 8'h00, 8'd0, 8'd0, 8'd0, 1'b0, 3'd3,
                 2'b01, 1'b1, 3'd2, 3'd3, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 5'b11111};
    vecs[12] = '{8'h00, 8'd0, 8'd0, 8'd0, 8'h00, 8'd0, 8'd0, 8'd0, 1'b1, 3'd0,
                 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 5'b11111};

    rst_n = 1'b0;
    cv = 1'b0; ct = 3'd0;
    set_inst(8'h01, 8'd1, 8'd2, 8'd3, 8'h03, 8'd4, 8'd5, 8'd6);
    repeat (2) @(negedge clk);
    #1;
    chk("reset sel", 8'(sel), 8'd0);
    chk("reset busy", 8'(busy), 8'd0);
    chk("reset v0", 8'(v0), 8'd0);
    chk("reset v1", 8'(v1), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      set_inst(vecs[i].t1, vecs[i].d1, vecs[i].a1, vecs[i].b1,
               vecs[i].t2, vecs[i].d2, vecs[i].a2, vecs[i].b2);
      cv = vecs[i].cv; ct = vecs[i].ct;
      #1;
      chk($sformatf("v%0d sel", i), 8'(sel), 8'(vecs[i].sel));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d busy", i), 8'(busy), 8'(vecs[i].busy));
      chk($sformatf("v%0d v0", i), 8'(v0), 8'(vecs[i].v0));
      chk($sformatf("v%0d v1", i), 8'(v1), 8'(vecs[i].v1));
      if (vecs[i].v0) begin
        chk($sformatf("v%0d rs0", i), 8'(rs0), 8'(vecs[i].rs0));
        chk($sformatf("v%0d qj0", i), 8'(qj0), 8'(vecs[i].qj0));
        chk($sformatf("v%0d qk0", i), 8'(qk0), 8'(vecs[i].qk0));
        chk($sformatf("v%0d op0", i), op0, vecs[i].t1);
        chk($sformatf("v%0d dest0", i), dst0, vecs[i].d1);
        chk($sformatf("v%0d src1_0", i), s10, vecs[i].a1);
        chk($sformatf("v%0d src2_0", i), s20, vecs[i].b1);
      end
      if (vecs[i].v1) begin
        chk($sformatf("v%0d rs1", i), 8'(rs1), 8'(vecs[i].rs1));
        chk($sformatf("v%0d qj1", i), 8'(qj1), 8'(vecs[i].qj1));
        chk($sformatf("v%0d qk1", i), 8'(qk1), 8'(vecs[i].qk1));
        chk($sformatf("v%0d op1", i), op1, vecs[i].t2);
        chk($sformatf("v%0d dest1", i), dst1, vecs[i].d2);
        chk($sformatf("v%0d src1_1", i), s11, vecs[i].a2);
        chk($sformatf("v%0d src2_1", i), s21, vecs[i].b2);
      end
      @(negedge clk);
    end

    // Structural stall: both mul RS busy, a MUL waits until tag 4 is broadcast.
    set_inst(8'h03, 8'd12, 8'd1, 8'd2, 8'h00, 8'd0, 8'd0, 8'd0);
    cv = 1'b0; ct = 3'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d sel", c), 8'(sel), 8'd0);
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d v0", c), 8'(v0), 8'd0);
      @(negedge clk);
    end
    cv = 1'b1; ct = 3'd4;
    #1;
    chk("stall cdb-cycle sel", 8'(sel), 8'd0);
    @(negedge clk);
    cv = 1'b0;
    chk("stall freed busy", 8'(busy), 8'b10111);
    #1;
    chk("stall release sel", 8'(sel), 8'd1);
    @(posedge clk);
    #1;
    chk("stall v0", 8'(v0), 8'd1);
    chk("stall rs0", 8'(rs0), 8'd4);
    chk("stall busy", 8'(busy), 8'b11111);

    // Async reset mid-cycle while an issue is being decided.
    @(negedge clk);
    set_inst(8'h00, 8'd0, 8'd0, 8'd0, 8'h00, 8'd0, 8'd0, 8'd0);
    cv = 1'b1; ct = 3'd1;
    @(negedge clk);
    cv = 1'b0;
    set_inst(8'h01, 8'd1, 8'h08, 8'd11, 8'h00, 8'd0, 8'd0, 8'd0);
    #1;
    chk("pre-reset sel", 8'(sel), 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset sel", 8'(sel), 8'd0);
    chk("midreset busy", 8'(busy), 8'd0);
    chk("midreset v0", 8'(v0), 8'd0);
    chk("midreset v1", 8'(v1), 8'd0);
    @(posedge clk);
    #1;
    chk("inreset v0", 8'(v0), 8'd0);
    chk("inreset busy", 8'(busy), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postreset sel", 8'(sel), 8'd1);
    @(posedge clk);
    #1;
    chk("postreset v0", 8'(v0), 8'd1);
    chk("postreset rs0", 8'(rs0), 8'd1);
    chk("postreset qj0", 8'(qj0), 8'd0);
    chk("postreset qk0", 8'(qk0), 8'd0);
    chk("postreset busy", 8'(busy), 8'b00001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dual_issue_dispatch.md
Name: dual_issue_dispatch

Overview:
- Consumer end of the instruction-queue interface: takes the two head instructions (type, destination, source1, source2) presented by the queue and returns `select_instruction` telling the queue how many to advance.
- Issues up to two instructions per cycle, in order, into Tomasulo reservation stations (RS).
- Renames destinations through a register status table, marks RS busy, and frees RS and status entries on common data bus (CDB) broadcasts.

Parameters:
NUM_ADD_RS, 3, adder-class RS count; tags 1..NUM_ADD_RS
NUM_MUL_RS, 2, multiplier-class RS count; tags NUM_ADD_RS+1..NUM_ADD_RS+NUM_MUL_RS
NUM_REGS, 16, architectural registers; register index = low log2(NUM_REGS) bits of each 8-bit register field
TAG_W, 3, tag width; tag 0 = operand ready (no producer)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
inst1_type, inst1_destination_reg, inst1_source_reg1, inst1_source_reg2  in  8 each  queue head instruction
inst2_type, inst2_destination_reg, inst2_source_reg1, inst2_source_reg2  in  8 each  queue head+1 instruction
select_instruction  out  2  00 hold, 01 advance 1, 10 advance 2 (11 never driven)
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  tag of completing RS
issue0_valid, issue1_valid  out  1  lane issued last cycle (lane0 = inst1)
issue0_rs, issue1_rs  out  TAG_W  allocated RS tag
issue0_op, issue1_op  out  8  instruction type
issue0_dest, issue1_dest  out  8  destination field
issue0_src1, issue0_src2, issue1_src1, issue1_src2  out  8  source fields
issue0_qj, issue0_qk, issue1_qj, issue1_qk  out  TAG_W  producer tag per source, 0 = ready
rs_busy  out  NUM_ADD_RS+NUM_MUL_RS  busy bit per RS, bit i = tag i+1

Behaviour:
- Decode:
  - type 0x00 = bubble (empty queue slot).
  - 0x03 MUL and 0x04 DIV = mul class.
  - Any other nonzero type = add class.
- Allocation: lowest-index free RS of the class. Two same-class issues take the two lowest free.
  - An RS freed by CDB in cycle N is allocatable from cycle N+1 only.
- Issue decision (combinational, from current inputs and state):
  - inst1 issues iff non-bubble and its class has a free RS.
  - inst2 issues iff inst1 issues, inst2 is non-bubble, and a free RS remains after inst1's allocation.
- select_instruction = number issued (00/01/10), combinational; forced 00 while rst_n low.
- Issue outputs are registered: one-cycle latency from the decision edge. issueX_valid is cleared on any cycle with no issue on that lane; other lane fields hold their last value.
- Operand tags: qj/qk = status[src] at the decision.
  - If cdb_valid and status[src] == cdb_tag, the tag is 0 (same-cycle bypass).
  - inst2 sources equal to inst1 dest (when inst1 issues) take inst1's allocated tag; this overrides status and bypass.
- Status update at the edge:
  - status[dest] <= allocated tag for each issued instruction; if both write the same dest, inst2's tag wins.
  - Otherwise, entries equal to cdb_tag (cdb_valid) clear to 0; an issue write to the same entry beats the CDB clear.
- rs_busy: set on allocation; cleared when cdb_valid and cdb_tag matches.
  - cdb_tag of 0 or a tag out of range is ignored.
  - CDB for an idle RS is a no-op.
- Reset (async, any time, including mid-issue):
  - rs_busy = 0, all status = 0.
  - All issue outputs = 0.
  - select_instruction = 00.
  - Instructions presented during reset are not consumed.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle after traffic -> immediately select=00, rs_busy=0, issue*_valid=0; next issue after release reads all qj/qk=0.
2. Dual issue, independent: inst1 ADD(0x01) R1,R2,R3 and inst2 MUL(0x03) R4,R5,R6 -> select=10 same cycle. Next cycle:
   - issue0_rs=1, issue1_rs=4, all q=0, rs_busy=01001.
3. Intra-pair RAW/WAW: inst1 ADD R1,R2,R3 and inst2 SUB(0x02) R1,R1,R2 -> issue1_qj=1, issue1_rs=2; status[R1]=2 afterwards.
4. Structural stall: two MULs fill RS 4,5; third MUL presented -> select=00 for every cycle until cdb tag 4. Then:
   - cycle after the CDB: select=01; next cycle issue0_rs=4.
5. CDB bypass: status[R1]=1, then cdb_valid with tag 1 in the same cycle that ADD R3,R1,R1 issues -> issue0_qj=issue0_qk=0; status[R1] ends 0, status[R3]=new tag.
6. Bubble handling: inst1=0x00 with inst2 valid -> select=00, no issue. inst1 valid with inst2=0x00 -> select=01, only lane0 valid.
